gpu_fill_rect_lanes: RTL and testbench
======================================

Name: gpu_fill_rect_lanes

Overview:
Parametrised successor of the GPU rectangle rasteriser. Takes two arbitrary corners plus a clip window and a fill colour, and emits the covered pixels in raster order. Output is groups of LANES horizontally adjacent pixels per beat, with a lane mask, under a valid/ready handshake. Sits between the command decoder and the framebuffer write arbiter.

Parameters:
WIDTH_BITS, 10, x coordinate width (screen up to 1024 px)
HEIGHT_BITS, 9, y coordinate width (up to 512 lines)
COLOR_BITS, 16, pixel colour width
LANES, 4, pixels per output beat (power of two, 1..16)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start_i  in  1  command strobe; sampled only in IDLE
x1_i, x2_i  in  WIDTH_BITS  corner x coords, any order
y1_i, y2_i  in  HEIGHT_BITS  corner y coords, any order
clip_x0_i, clip_x1_i  in  WIDTH_BITS  inclusive clip x range (x0<=x1 guaranteed by driver)
clip_y0_i, clip_y1_i  in  HEIGHT_BITS  inclusive clip y range
color_i  in  COLOR_BITS  fill colour, latched with start
abort_i  in  1  cancel current fill
x_o  out  WIDTH_BITS  x of lane 0 of current beat
y_o  out  HEIGHT_BITS  row of current beat
mask_o  out  LANES  bit k set => pixel (x_o+k, y_o) is to be written
color_o  out  COLOR_BITS  latched fill colour
valid_o  out  1  beat valid
ready_i  in  1  downstream accepts beat
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: state IDLE; valid_o, busy_o and done_o are 0; x_o, y_o, mask_o and color_o are 0. rst overrides everything, including mid-fill; no done_o is generated.
- States: IDLE -> SETUP -> SCAN -> FINISH -> IDLE.
- IDLE: when start_i=1, latch corners, clip window and colour, then go to SETUP. start_i is ignored in all other states.
- SETUP (1 cycle), registered:
  - xmin = max(min(x1,x2), clip_x0); xmax = min(max(x1,x2), clip_x1); ymin and ymax likewise.
  - If xmin>xmax or ymin>ymax, the rectangle is empty: go to FINISH with no beats emitted.
  - Otherwise load x=xmin, y=ymin and go to SCAN.
- Latency: start_i sampled at cycle N; first valid_o=1 at cycle N+2.
- SCAN:
  - valid_o=1. mask_o[k] = (x+k <= xmax), computed at WIDTH_BITS+1 width so x+k never wraps at the top coordinate.
  - Lane 0 is always set. Beats are not aligned to LANES boundaries; x_o starts at xmin for each row.
  - On valid_o & ready_i: if x+LANES > xmax (row end), then on the last row (y==ymax) go to FINISH, else set x=xmin and y=y+1. Otherwise x=x+LANES. This comparison is also done at extended width.
  - When ready_i=0: x_o, y_o, mask_o and color_o hold stable and valid_o stays 1 (AXI-style; no valid drop).
- FINISH: done_o=1 for exactly this cycle, valid_o=0, then IDLE. busy_o is still 1 in FINISH.
- abort_i: in SETUP or SCAN, go to IDLE next cycle. valid_o drops that cycle, any in-flight beat is not counted, and no done_o is generated. In IDLE or FINISH, abort_i is ignored.
- Beat count per row = ceil((xmax-xmin+1)/LANES). Total beats = rows × beats per row.
- A zero-size rectangle (x1==x2, y1==y2) inside the clip window produces exactly 1 beat with mask = 1.

Decomposition:
- Shared package gpu_pkg (extends gpu_definitions): fill_state_t enum {IDLE, SETUP, SCAN, FINISH}; point_t struct {x, y}; rect_t struct {xmin, xmax, ymin, ymax}.
- One sub-module, gpu_rect_setup: combinational normalise plus clip intersect producing rect_t and an empty flag. It is reused by the future line and blit engines.
- The top level holds the FSM, the x/y counters and the mask generator.

Test Plan:
- Basic: LANES=4, corners (0,0)-(200,150), full-screen clip, ready_i=1. Required: 51 beats/row × 151 rows = 7701 beats; each row's last beat has x_o=200 and mask 0001; done_o exactly once, 1 cycle after the final handshake; first valid 2 cycles after start.
- Swapped corners (200,150)-(0,0): beat stream identical to the basic case. Clip (50,20)-(57,21) on the same rect: beats (50,20,1111), (54,20,1111), (50,21,1111), (54,21,1111), then done.
- Empty: rect (10,10)-(20,20) with clip x 30..40. Required: zero beats, busy_o high 2 cycles, done_o pulses at cycle N+2.
- Backpressure: random ready_i at 30% duty on a (3,3)-(9,4) rect. Required: outputs stable while valid & !ready; exactly 4 beats: (3,3,1111), (7,3,0111), (3,4,1111), (7,4,0111).
- Edge: x1=x2=1020, x2 range to 1023, WIDTH_BITS=10. Required: single beat per row at x_o=1020, mask 1111, no wrap to x=0.
- Abort/reset: abort_i at the 5th beat with ready_i=1 gives IDLE next cycle and no done_o; a new start is then accepted. rst asserted mid-SCAN gives all outputs 0 on the following cycle.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU types for the fill, line and blit engines.
// Coordinates are carried at a fixed 16-bit width and zero-extended from each engine's own widths.
package gpu_pkg;

  localparam int COORD_BITS = 16;

  typedef logic [COORD_BITS-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SCAN,
    FINISH
  } fill_state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef struct packed {
    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;
  } rect_t;

  function automatic coord_t coord_min(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t coord_max(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gpu_rect_setup.sv
// Normalises two arbitrary corners and intersects them with an inclusive clip window.
// Purely combinational so the line and blit engines can register it where they need.
module gpu_rect_setup
  import gpu_pkg::*;
(
  input  point_t      p1,
  input  point_t      p2,
  input  rect_t       clip,
  output rect_t       rect,
  output logic        empty
);

  always_comb begin
    rect.xmin = coord_max(coord_min(p1.x, p2.x), clip.xmin);
    rect.xmax = coord_min(coord_max(p1.x, p2.x), clip.xmax);
    rect.ymin = coord_max(coord_min(p1.y, p2.y), clip.ymin);
    rect.ymax = coord_min(coord_max(p1.y, p2.y), clip.ymax);
    empty     = (rect.xmin > rect.xmax) || (rect.ymin > rect.ymax);
  end

endmodule

// File: rtl/gpu_fill_rect_lanes.sv
// Rectangle fill rasteriser: emits LANES adjacent pixels per beat in raster order,
// with a lane mask, under a valid/ready handshake.
module gpu_fill_rect_lanes
  import gpu_pkg::*;
#(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int COLOR_BITS  = 16,
  parameter int LANES       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [WIDTH_BITS-1:0]  x1_i,
  input  logic [WIDTH_BITS-1:0]  x2_i,
  input  logic [HEIGHT_BITS-1:0] y1_i,
  input  logic [HEIGHT_BITS-1:0] y2_i,
  input  logic [WIDTH_BITS-1:0]  clip_x0_i,
  input  logic [WIDTH_BITS-1:0]  clip_x1_i,
  input  logic [HEIGHT_BITS-1:0] clip_y0_i,
  input  logic [HEIGHT_BITS-1:0] clip_y1_i,
  input  logic [COLOR_BITS-1:0]  color_i,
  input  logic                   abort_i,
  output logic [WIDTH_BITS-1:0]  x_o,
  output logic [HEIGHT_BITS-1:0] y_o,
  output logic [LANES-1:0]       mask_o,
  output logic [COLOR_BITS-1:0]  color_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic                   done_o
);

  // One extra bit so x+k and x+LANES never wrap at the right screen edge.
  localparam int XW = COORD_BITS + 1;

  fill_state_t state, state_next;

  point_t                 p1_q, p2_q;
  rect_t                  clip_q, rect_c, rect_q;
  logic                   empty_c;
  logic [WIDTH_BITS-1:0]  x_q;
  logic [HEIGHT_BITS-1:0] y_q;
  logic [COLOR_BITS-1:0]  color_q;

  logic [XW-1:0] x_ext, xmax_ext;
  logic          row_end, last_row, beat_taken;
  logic          unused_hi_bits;

  gpu_rect_setup u_setup (
    .p1    (p1_q),
    .p2    (p2_q),
    .clip  (clip_q),
    .rect  (rect_c),
    .empty (empty_c)
  );

  assign x_ext    = XW'(x_q);
  assign xmax_ext = XW'(rect_q.xmax);
  assign row_end  = (x_ext + XW'(LANES)) > xmax_ext;
  assign last_row = (coord_t'(y_q) == rect_q.ymax);

  // Minimum corners are only consumed at the engine's native widths.
  assign unused_hi_bits = ^{rect_c.xmin, rect_c.ymin, rect_q.xmin, rect_q.ymin};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    valid_o    = 1'b0;
    done_o     = 1'b0;
    beat_taken = 1'b0;
    case (state)
      IDLE:   if (start_i) state_next = SETUP;
      SETUP: begin
        if (abort_i)      state_next = IDLE;
        else if (empty_c) state_next = FINISH;
        else              state_next = SCAN;
      end
      SCAN: begin
        // An abort withdraws the in-flight beat so it can never be accepted.
        if (abort_i) begin
          state_next = IDLE;
        end else begin
          valid_o = 1'b1;
          if (ready_i) begin
            beat_taken = 1'b1;
            if (row_end && last_row) state_next = FINISH;
          end
        end
      end
      FINISH: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mask_o = '0;
    if (state == SCAN) begin
      for (int k = 0; k < LANES; k++) begin
        mask_o[k] = (x_ext + XW'(k)) <= xmax_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q    <= '0;
      p2_q    <= '0;
      clip_q  <= '0;
      rect_q  <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          p1_q    <= '{x: coord_t'(x1_i), y: coord_t'(y1_i)};
          p2_q    <= '{x: coord_t'(x2_i), y: coord_t'(y2_i)};
          clip_q  <= '{xmin: coord_t'(clip_x0_i), xmax: coord_t'(clip_x1_i),
                       ymin: coord_t'(clip_y0_i), ymax: coord_t'(clip_y1_i)};
          color_q <= color_i;
        end
        SETUP: begin
          rect_q <= rect_c;
          x_q    <= rect_c.xmin[WIDTH_BITS-1:0];
          y_q    <= rect_c.ymin[HEIGHT_BITS-1:0];
        end
        SCAN: if (beat_taken) begin
          if (row_end) begin
            if (!last_row) begin
              x_q <= rect_q.xmin[WIDTH_BITS-1:0];
              y_q <= y_q + HEIGHT_BITS'(1);
            end
          end else begin
            x_q <= x_q + WIDTH_BITS'(LANES);
          end
        end
        default: ;
      endcase
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign color_o = color_q;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_gpu_fill_rect_lanes.sv
// Directed bench for gpu_fill_rect_lanes: a vector table of fills plus abort and reset sequences.
module tb_gpu_fill_rect_lanes;

  localparam int WB = 10;
  localparam int HB = 9;
  localparam int CB = 16;
  localparam int LN = 4;
  localparam int BUDGET = 20000;

  logic          tb_clk = 1'b0;
  logic          rst, start_i, abort_i, ready_i;
  logic [WB-1:0] x1_i, x2_i, clip_x0_i, clip_x1_i, x_o;
  logic [HB-1:0] y1_i, y2_i, clip_y0_i, clip_y1_i, y_o;
  logic [CB-1:0] color_i, color_o;
  logic [LN-1:0] mask_o;
  logic          valid_o, busy_o, done_o;

  always #5 tb_clk = ~tb_clk;

  gpu_fill_rect_lanes #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .COLOR_BITS(CB), .LANES(LN)) dut (
    .clk(tb_clk), .rst(rst), .start_i(start_i),
    .x1_i(x1_i), .x2_i(x2_i), .y1_i(y1_i), .y2_i(y2_i),
    .clip_x0_i(clip_x0_i), .clip_x1_i(clip_x1_i), .clip_y0_i(clip_y0_i), .clip_y1_i(clip_y1_i),
    .color_i(color_i), .abort_i(abort_i),
    .x_o(x_o), .y_o(y_o), .mask_o(mask_o), .color_o(color_o),
    .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    int x1, y1, x2, y2, cx0, cx1, cy0, cy1;
    int color, ready_pct, exp_count;
    int fx, fy, fm, lx, ly, lm;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  int r_count, r_first_k, r_last_k, r_done_k, r_done_n, r_busy, r_stream_err, r_hold_err;
  logic [WB+HB+LN-1:0] r_first, r_last;
  bit r_finished;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input int x1, y1, x2, y2, cx0, cx1, cy0, cy1,
                                  input int pct, cnt, fx, fy, fm, lx, ly, lm);
    vec_t v;
    v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
    v.cx0 = cx0; v.cx1 = cx1; v.cy0 = cy0; v.cy1 = cy1;
    v.color = 16'hA000 + vecs.size(); v.ready_pct = pct; v.exp_count = cnt;
    v.fx = fx; v.fy = fy; v.fm = fm; v.lx = lx; v.ly = ly; v.lm = lm;
    vecs.push_back(v);
  endfunction

  task automatic drive_start(input vec_t v);
    @(posedge tb_clk); #1;
    x1_i = WB'(v.x1); y1_i = HB'(v.y1); x2_i = WB'(v.x2); y2_i = HB'(v.y2);
    clip_x0_i = WB'(v.cx0); clip_x1_i = WB'(v.cx1);
    clip_y0_i = HB'(v.cy0); clip_y1_i = HB'(v.cy1);
    color_i = CB'(v.color); start_i = 1'b1;
    @(posedge tb_clk); #1;
    // Scramble the command inputs so only latched values can produce correct beats.
    start_i = 1'b0; color_i = ~CB'(v.color);
    x1_i = 7; x2_i = 9; y1_i = 3; y2_i = 4;
  endtask

  task automatic apply_stimulus(input vec_t v);
    int xmin, xmax, ymin, ymax, mx, my, k;
    logic [LN-1:0] em;
    logic [WB+HB+LN+CB-1:0] held;
    bit have_hold;
    xmin = (v.x1 < v.x2) ? v.x1 : v.x2;  xmin = (xmin > v.cx0) ? xmin : v.cx0;
    xmax = (v.x1 > v.x2) ? v.x1 : v.x2;  xmax = (xmax < v.cx1) ? xmax : v.cx1;
    ymin = (v.y1 < v.y2) ? v.y1 : v.y2;  ymin = (ymin > v.cy0) ? ymin : v.cy0;
    ymax = (v.y1 > v.y2) ? v.y1 : v.y2;  ymax = (ymax < v.cy1) ? ymax : v.cy1;
    mx = xmin; my = ymin;
    r_count = 0; r_first_k = -1; r_last_k = -1; r_done_k = -1; r_done_n = 0; r_busy = 0;
    r_stream_err = 0; r_hold_err = 0; r_finished = 0; have_hold = 0; held = '0;
    r_first = '0; r_last = '0;
    drive_start(v);
    k = 1;
    while (k < BUDGET && !r_finished) begin
      if (v.ready_pct >= 100) ready_i = 1'b1;
      else if (k == 2)        ready_i = 1'b0;
      else                    ready_i = ($urandom_range(0, 99) < v.ready_pct);
      @(negedge tb_clk);
      if (busy_o) r_busy++;
      if (done_o) begin
        r_done_n++;
        if (r_done_k < 0) r_done_k = k;
      end
      if (valid_o) begin
        if (r_first_k < 0) r_first_k = k;
        if (have_hold && {x_o, y_o, mask_o, color_o} !== held) r_hold_err++;
        if (ready_i) begin
          for (int i = 0; i < LN; i++) em[i] = (mx + i <= xmax);
          if (my > ymax || x_o !== WB'(mx) || y_o !== HB'(my) || mask_o !== em ||
              color_o !== CB'(v.color)) r_stream_err++;
          if (mx + LN > xmax) begin mx = xmin; my++; end
          else mx = mx + LN;
          if (r_count == 0) r_first = {x_o, y_o, mask_o};
          r_last = {x_o, y_o, mask_o};
          r_last_k = k;
          r_count++;
          have_hold = 0;
        end else begin
          have_hold = 1;
          held = {x_o, y_o, mask_o, color_o};
        end
      end else if (have_hold) begin
        r_hold_err++;
        have_hold = 0;
      end
      if (r_done_k >= 0 && k >= r_done_k + 2) r_finished = 1;
      k++;
      @(posedge tb_clk); #1;
    end
    ready_i = 1'b1;
  endtask

  task automatic run_and_check(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    apply_stimulus(v);
    check_output({tag, "_timeout"}, r_finished, 1);
    check_output({tag, "_count"}, r_count, v.exp_count);
    check_output({tag, "_stream"}, r_stream_err, 0);
    check_output({tag, "_hold"}, r_hold_err, 0);
    check_output({tag, "_done_n"}, r_done_n, 1);
    if (v.exp_count > 0) begin
      check_output({tag, "_first"}, r_first, {WB'(v.fx), HB'(v.fy), LN'(v.fm)});
      check_output({tag, "_last"}, r_last, {WB'(v.lx), HB'(v.ly), LN'(v.lm)});
      check_output({tag, "_lat"}, r_first_k, 2);
      check_output({tag, "_done_k"}, r_done_k, r_last_k + 1);
    end else begin
      check_output({tag, "_done_k"}, r_done_k, 2);
    end
    if (v.ready_pct >= 100) check_output({tag, "_busy"}, r_busy, v.exp_count + 2);
  endtask

  task automatic wait_beats(input int n, output int hs);
    int k;
    hs = 0; k = 0;
    while (hs < n && k < 100) begin
      @(negedge tb_clk);
      if (valid_o && ready_i) hs++;
      k++;
      @(posedge tb_clk); #1;
    end
  endtask

  initial begin
    vec_t big;
    int hs, dn;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
    x1_i = '0; x2_i = '0; y1_i = '0; y2_i = '0;
    clip_x0_i = '0; clip_x1_i = '0; clip_y0_i = '0; clip_y1_i = '0; color_i = '0;

    add_vec(0, 0, 200, 150,     0, 1023, 0, 511, 100, 7701,  0, 0, 4'hF,  200, 150, 4'h1);
    add_vec(200, 150, 0, 0,     0, 1023, 0, 511, 100, 7701,  0, 0, 4'hF,  200, 150, 4'h1);
    add_vec(0, 0, 200, 150,     50, 57, 20, 21,  100, 4,     50, 20, 4'hF, 54, 21, 4'hF);
    add_vec(10, 10, 20, 20,     30, 40, 0, 511,  100, 0,     0, 0, 0,      0, 0, 0);
    add_vec(3, 3, 9, 4,         0, 1023, 0, 511, 30,  4,     3, 3, 4'hF,   7, 4, 4'h7);
    add_vec(1020, 5, 1023, 7,   0, 1023, 0, 511, 100, 3,     1020, 5, 4'hF, 1020, 7, 4'hF);
    add_vec(1023, 0, 1023, 0,   0, 1023, 0, 511, 100, 1,     1023, 0, 4'h1, 1023, 0, 4'h1);
    add_vec(5, 5, 5, 5,         0, 1023, 0, 511, 100, 1,     5, 5, 4'h1,   5, 5, 4'h1);
    add_vec(0, 0, 10, 0,        2, 8, 0, 511,    40,  2,     2, 0, 4'hF,   6, 0, 4'h7);
    add_vec(0, 100, 50, 120,    0, 1023, 0, 50,  100, 0,     0, 0, 0,      0, 0, 0);

    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    check_output("reset_state", {x_o, y_o, mask_o, color_o, valid_o, busy_o, done_o}, 0);
    @(posedge tb_clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_and_check(vecs[i], i);

    // Abort while the fifth beat is on the bus, then confirm a fresh command still runs.
    big = vecs[0];
    drive_start(big);
    wait_beats(4, hs);
    check_output("abort_reach", hs, 4);
    abort_i = 1'b1;
    @(posedge tb_clk); #1;
    abort_i = 1'b0;
    @(negedge tb_clk);
    check_output("abort_idle", {busy_o, valid_o, done_o}, 0);
    dn = 0;
    repeat (5) begin @(negedge tb_clk); if (done_o) dn++; end
    check_output("abort_nodone", dn, 0);
    run_and_check(vecs[4], 100);

    // Reset in the middle of a scan clears everything on the next cycle.
    drive_start(big);
    wait_beats(3, hs);
    check_output("rst_reach", hs, 3);
    rst = 1'b1;
    @(posedge tb_clk);
    @(negedge tb_clk);
    check_output("rst_midscan", {x_o, y_o, mask_o, color_o, valid_o, busy_o, done_o}, 0);
    @(posedge tb_clk); #1;
    rst = 1'b0;
    dn = 0;
    repeat (5) begin @(negedge tb_clk); if (done_o || busy_o) dn++; end
    check_output("rst_quiet", dn, 0);
    run_and_check(vecs[2], 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
